// File: rtl/pum_xbox_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : pum_xbox_if
// Description : Xbox memory port and PUM compute handshake bundle between the
//               BNN pass sequencer (master) and the datapath/memory (slave).
//               mem_req/mem_we/mem_addr : registered request, held until gnt
//               mem_gnt                 : request accepted this cycle
//               mem_rvalid              : read data valid on xbox rdata
//               ld_r1/ld_r2             : capture rdata into R1/R2
//               cmp_start/cmp_done      : compute trigger / completion
// Revision    : 1.0 - initial release
// ============================================================================
interface pum_xbox_if #(
  parameter int ADDR_W = 14
) ();
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic              ld_r1;
  logic              ld_r2;
  logic              cmp_start;
  logic              cmp_done;

  modport master (
    output mem_req, mem_we, mem_addr, ld_r1, ld_r2, cmp_start,
    input  mem_gnt, mem_rvalid, cmp_done
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, ld_r1, ld_r2, cmp_start,
    output mem_gnt, mem_rvalid, cmp_done
  );
endinterface
`default_nettype wire

// File: rtl/pum_xbox_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : pum_xbox_sequencer
// Description : Sequences a full BNN pass of the PUM datapath over the xbox
//               memory: per weight row load R2, then per input row load R1,
//               trigger compute, wait for completion and write RA back.
// Ports       : clk, rst_n           - clock, async active-low reset
//               cfg_start_i/abort_i  - start pulse (IDLE only) / abort
//               cfg_base_[abc]_i     - R1 / R2 / RA base rows
//               cfg_n_in_i/n_w_i     - input / weight row counts
//               busy_o, done_o, err_o- status to the register file
//               xbox                 - memory port and compute handshake
// Revision    : 1.0 - initial release
// ============================================================================
module pum_xbox_sequencer #(
  parameter int ADDR_W  = 14,
  parameter int CNT_W   = 15,
  parameter int TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_start_i,
  input  logic              cfg_abort_i,
  input  logic [ADDR_W-1:0] cfg_base_a_i,
  input  logic [ADDR_W-1:0] cfg_base_b_i,
  input  logic [ADDR_W-1:0] cfg_base_c_i,
  input  logic [CNT_W-1:0]  cfg_n_in_i,
  input  logic [CNT_W-1:0]  cfg_n_w_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  pum_xbox_if.master        xbox
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_REQ_R2  = 3'd1;
  localparam logic [2:0] S_WAIT_R2 = 3'd2;
  localparam logic [2:0] S_REQ_R1  = 3'd3;
  localparam logic [2:0] S_WAIT_R1 = 3'd4;
  localparam logic [2:0] S_COMPUTE = 3'd5;
  localparam logic [2:0] S_WR_RA   = 3'd6;
  localparam logic [2:0] S_DONE    = 3'd7;

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] base_a_q, base_a_d;
  logic [ADDR_W-1:0] base_b_q, base_b_d;
  logic [ADDR_W-1:0] c_ptr_q, c_ptr_d;
  logic [CNT_W-1:0]  n_in_q, n_in_d;
  logic [CNT_W-1:0]  n_w_q, n_w_d;
  logic [CNT_W-1:0]  i_cnt_q, i_cnt_d;
  logic [CNT_W-1:0]  w_cnt_q, w_cnt_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic              err_q, err_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              cmp_start_q, cmp_start_d;

  // One bit wider so the "last row" compare cannot overflow.
  logic [CNT_W:0]    i_nxt, w_nxt;
  assign i_nxt = {1'b0, i_cnt_q} + {{CNT_W{1'b0}}, 1'b1};
  assign w_nxt = {1'b0, w_cnt_q} + {{CNT_W{1'b0}}, 1'b1};

  always_comb begin
    state_d  = state_q;
    base_a_d = base_a_q;
    base_b_d = base_b_q;
    c_ptr_d  = c_ptr_q;
    n_in_d   = n_in_q;
    n_w_d    = n_w_q;
    i_cnt_d  = i_cnt_q;
    w_cnt_d  = w_cnt_q;
    wd_d     = wd_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE: begin
        if (cfg_start_i) begin
          base_a_d = cfg_base_a_i;
          base_b_d = cfg_base_b_i;
          c_ptr_d  = cfg_base_c_i;
          n_in_d   = cfg_n_in_i;
          n_w_d    = cfg_n_w_i;
          i_cnt_d  = '0;
          w_cnt_d  = '0;
          err_d    = 1'b0;
          if (cfg_n_in_i == '0 || cfg_n_w_i == '0) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_REQ_R2;
          end
        end
      end
      S_REQ_R2:  if (xbox.mem_gnt) state_d = S_WAIT_R2;
      S_WAIT_R2: begin
        if (xbox.mem_rvalid) begin
          i_cnt_d = '0;
          state_d = S_REQ_R1;
        end
      end
      S_REQ_R1:  if (xbox.mem_gnt) state_d = S_WAIT_R1;
      S_WAIT_R1: begin
        if (xbox.mem_rvalid) begin
          wd_d    = '0;
          state_d = S_COMPUTE;
        end
      end
      S_COMPUTE: begin
        if (xbox.cmp_done) begin
          state_d = S_WR_RA;
        end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      S_WR_RA: begin
        if (xbox.mem_gnt) begin
          // Running pointer yields base_c + w*n_in + i without a multiplier.
          c_ptr_d = c_ptr_q + 1'b1;
          if (i_nxt < {1'b0, n_in_q}) begin
            i_cnt_d = i_nxt[CNT_W-1:0];
            state_d = S_REQ_R1;
          end else if (w_nxt < {1'b0, n_w_q}) begin
            w_cnt_d = w_nxt[CNT_W-1:0];
            state_d = S_REQ_R2;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      default:   state_d = S_IDLE;  // S_DONE
    endcase
    // Abort wins over every other transition and leaves err untouched.
    if (cfg_abort_i && state_q != S_IDLE) begin
      state_d = S_IDLE;
      err_d   = err_q;
    end
  end

  // Request outputs are derived from the next state so they are registered and
  // naturally hold while a request waits for its grant.
  always_comb begin
    req_d       = (state_d == S_REQ_R2) || (state_d == S_REQ_R1) || (state_d == S_WR_RA);
    we_d        = (state_d == S_WR_RA);
    cmp_start_d = (state_d == S_COMPUTE) && (state_q != S_COMPUTE);
    case (state_d)
      S_REQ_R2: addr_d = base_b_d + ADDR_W'(w_cnt_d);
      S_REQ_R1: addr_d = base_a_d + ADDR_W'(i_cnt_d);
      S_WR_RA:  addr_d = c_ptr_d;
      default:  addr_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      base_a_q    <= '0;
      base_b_q    <= '0;
      c_ptr_q     <= '0;
      n_in_q      <= '0;
      n_w_q       <= '0;
      i_cnt_q     <= '0;
      w_cnt_q     <= '0;
      wd_q        <= '0;
      err_q       <= 1'b0;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      cmp_start_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_a_q    <= base_a_d;
      base_b_q    <= base_b_d;
      c_ptr_q     <= c_ptr_d;
      n_in_q      <= n_in_d;
      n_w_q       <= n_w_d;
      i_cnt_q     <= i_cnt_d;
      w_cnt_q     <= w_cnt_d;
      wd_q        <= wd_d;
      err_q       <= err_d;
      req_q       <= req_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      cmp_start_q <= cmp_start_d;
    end
  end

  assign busy_o         = (state_q != S_IDLE);
  assign done_o         = (state_q == S_DONE);
  assign err_o          = err_q;
  assign xbox.mem_req   = req_q;
  assign xbox.mem_we    = we_q;
  assign xbox.mem_addr  = addr_q;
  assign xbox.cmp_start = cmp_start_q;
  assign xbox.ld_r1     = (state_q == S_WAIT_R1) && xbox.mem_rvalid;
  assign xbox.ld_r2     = (state_q == S_WAIT_R2) && xbox.mem_rvalid;

endmodule
`default_nettype wire

// File: tb/tb_pum_xbox_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_pum_xbox_sequencer
// Description : Scoreboard bench for pum_xbox_sequencer. A pass-level model
//               queues the expected xbox transactions and end-of-pass status;
//               a monitor pops and compares as the DUT presents them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pum_xbox_sequencer;
  localparam int ADDR_W  = 14;
  localparam int CNT_W   = 15;
  localparam int TIMEOUT = 1023;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              cfg_start = 1'b0, cfg_abort = 1'b0;
  logic [ADDR_W-1:0] cfg_base_a = '0, cfg_base_b = '0, cfg_base_c = '0;
  logic [CNT_W-1:0]  cfg_n_in = '0, cfg_n_w = '0;
  logic              busy, done, err;

  pum_xbox_if #(.ADDR_W(ADDR_W)) xbox ();

  pum_xbox_sequencer #(.ADDR_W(ADDR_W), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_start_i(cfg_start), .cfg_abort_i(cfg_abort),
    .cfg_base_a_i(cfg_base_a), .cfg_base_b_i(cfg_base_b), .cfg_base_c_i(cfg_base_c),
    .cfg_n_in_i(cfg_n_in), .cfg_n_w_i(cfg_n_w),
    .busy_o(busy), .done_o(done), .err_o(err),
    .xbox(xbox)
  );

  typedef struct packed { logic we; logic [ADDR_W-1:0] addr; } txn_t;
  typedef struct { logic err; int n_r1; int n_r2; int n_cmp; bit wd; } end_t;

  txn_t exp_txn[$];
  end_t exp_end[$];
  int   checks = 0, errors = 0;
  longint cyc = 0;
  int   gnt_mode = 0, rv_mode = 0, cmp_mode = 1;

  function automatic void chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  function automatic void fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endfunction

  function automatic txn_t mk(input logic we, input int addr);
    txn_t t;
    t.we   = we;
    t.addr = addr[ADDR_W-1:0];
    return t;
  endfunction

  // Pass-level reference: nested loops over weight and input rows.
  function automatic void push_model(input int a, input int b, input int c,
                                     input int nin, input int nw, input bit wd);
    end_t e;
    if (nin == 0 || nw == 0) begin
      e = '{1'b1, 0, 0, 0, 1'b0};
    end else if (wd) begin
      exp_txn.push_back(mk(1'b0, b));
      exp_txn.push_back(mk(1'b0, a));
      e = '{1'b1, 1, 1, 1, 1'b1};
    end else begin
      for (int w = 0; w < nw; w++) begin
        exp_txn.push_back(mk(1'b0, b + w));
        for (int i = 0; i < nin; i++) begin
          exp_txn.push_back(mk(1'b0, a + i));
          exp_txn.push_back(mk(1'b1, c + w * nin + i));
        end
      end
      e = '{1'b0, nw * nin, nw, nw * nin, 1'b0};
    end
    exp_end.push_back(e);
  endfunction

  // ---------------- memory responder ----------------
  bit in_req = 0, rv_pend = 0;
  int gnt_wait = 0, rv_wait = 0;
  initial begin
    xbox.mem_gnt = 1'b0;
    xbox.mem_rvalid = 1'b0;
    forever begin
      @(posedge clk); #1;
      xbox.mem_gnt = 1'b0;
      xbox.mem_rvalid = 1'b0;
      if (!rst_n) begin
        in_req = 0; rv_pend = 0;
      end else begin
        if (rv_pend) begin
          if (rv_wait == 0) begin xbox.mem_rvalid = 1'b1; rv_pend = 0; end
          else rv_wait--;
        end
        if (xbox.mem_req) begin
          if (!in_req) begin
            in_req = 1;
            gnt_wait = (gnt_mode == 0) ? 0 : (gnt_mode == 1) ? 5 : int'($urandom_range(0, 3));
          end
          if (gnt_wait == 0) begin
            xbox.mem_gnt = 1'b1;
            in_req = 0;
            if (!xbox.mem_we) begin
              rv_pend = 1;
              rv_wait = (rv_mode == 0) ? 0 : (rv_mode == 1) ? 4 : int'($urandom_range(0, 3));
            end
          end else begin
            gnt_wait--;
          end
        end
      end
    end
  end

  // ---------------- compute responder ----------------
  bit cmp_pend = 0;
  int cmp_wait = 0;
  initial begin
    xbox.cmp_done = 1'b0;
    forever begin
      @(posedge clk); #1;
      xbox.cmp_done = 1'b0;
      if (!rst_n) begin
        cmp_pend = 0;
      end else begin
        if (xbox.cmp_start && cmp_mode != 0) begin
          cmp_pend = 1;
          cmp_wait = (cmp_mode == 1) ? 2 : int'($urandom_range(0, 3));
        end
        if (cmp_pend) begin
          if (cmp_wait == 0) begin xbox.cmp_done = 1'b1; cmp_pend = 0; end
          else cmp_wait--;
        end
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  int     n_r1 = 0, n_r2 = 0, n_cmp = 0;
  longint cmp_cyc = 0;
  bit     stall = 0;
  txn_t   stall_t, mon_t;
  end_t   mon_e;
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        stall = 0; n_r1 = 0; n_r2 = 0; n_cmp = 0;
      end else begin
        if (stall)
          chk("req_hold", {xbox.mem_req, xbox.mem_we, xbox.mem_addr}, {1'b1, stall_t});
        if (xbox.mem_req && xbox.mem_gnt) begin
          if (exp_txn.size() == 0) fail("unexpected_xbox_txn");
          else begin
            mon_t = exp_txn.pop_front();
            chk("xbox_txn", {xbox.mem_we, xbox.mem_addr}, mon_t);
          end
        end
        stall   = xbox.mem_req && !xbox.mem_gnt;
        stall_t = {xbox.mem_we, xbox.mem_addr};
        if (xbox.ld_r1) n_r1++;
        if (xbox.ld_r2) n_r2++;
        if (xbox.cmp_start) begin n_cmp++; cmp_cyc = cyc; end
        if (done) begin
          if (exp_end.size() == 0) fail("unexpected_done");
          else begin
            mon_e = exp_end.pop_front();
            chk("done_err", err, mon_e.err);
            chk("ld_r1_count", n_r1, mon_e.n_r1);
            chk("ld_r2_count", n_r2, mon_e.n_r2);
            chk("cmp_start_count", n_cmp, mon_e.n_cmp);
            if (mon_e.wd) chk("watchdog_latency", cyc - cmp_cyc, TIMEOUT);
          end
        end
        if (!busy) begin
          chk("idle_quiet", {xbox.mem_req, xbox.mem_we, xbox.mem_addr, xbox.ld_r1,
                             xbox.ld_r2, xbox.cmp_start, done}, 0);
          n_r1 = 0; n_r2 = 0; n_cmp = 0;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive_cfg(input int a, input int b, input int c, input int nin, input int nw);
    cfg_base_a = a[ADDR_W-1:0];
    cfg_base_b = b[ADDR_W-1:0];
    cfg_base_c = c[ADDR_W-1:0];
    cfg_n_in   = nin[CNT_W-1:0];
    cfg_n_w    = nw[CNT_W-1:0];
  endtask

  task automatic scramble_cfg();
    drive_cfg(int'($urandom), int'($urandom), int'($urandom),
              int'($urandom_range(0, 5)), int'($urandom_range(0, 5)));
  endtask

  task automatic run_pass(input int a, input int b, input int c, input int nin,
                          input int nw, input bit wd, input bit midstart);
    bit got = 0;
    int budget = nw * nin * 60 + nw * 40 + (wd ? TIMEOUT : 0) + 100;
    push_model(a, b, c, nin, nw, wd);
    @(posedge clk); #1;
    drive_cfg(a, b, c, nin, nw);
    cfg_start = 1'b1;
    @(posedge clk); #1;
    cfg_start = 1'b0;
    scramble_cfg();
    if (midstart) begin
      repeat (5) @(posedge clk);
      #1;
      cfg_start = 1'b1;
      scramble_cfg();
      @(posedge clk); #1;
      cfg_start = 1'b0;
    end
    for (int k = 0; k < budget && !got; k++) begin
      @(negedge clk);
      if (done) got = 1;
    end
    if (!got) fail("pass_timeout");
    repeat (3) @(negedge clk);
    chk("txn_drain", exp_txn.size(), 0);
    chk("end_drain", exp_end.size(), 0);
  endtask

  task automatic zero_dim(input int nin, input int nw);
    bit got = 0;
    int lat = 0;
    push_model(0, 0, 0, nin, nw, 1'b0);
    @(posedge clk); #1;
    drive_cfg(int'($urandom), int'($urandom), int'($urandom), nin, nw);
    cfg_start = 1'b1;
    for (int k = 1; k <= 10 && !got; k++) begin
      @(negedge clk);
      if (k == 2) cfg_start = 1'b0;
      if (done) begin got = 1; lat = k; end
    end
    cfg_start = 1'b0;
    chk("zero_dim_done_latency", lat, 2);
    repeat (3) @(negedge clk);
    chk("zero_dim_drain", exp_end.size() + exp_txn.size(), 0);
  endtask

  task automatic abort_test();
    bit seen = 0;
    int a = int'($urandom_range(0, 16383));
    int b = int'($urandom_range(0, 16383));
    rv_mode = 1; gnt_mode = 0; cmp_mode = 1;
    exp_txn.push_back(mk(1'b0, b));
    exp_txn.push_back(mk(1'b0, a));
    @(posedge clk); #1;
    drive_cfg(a, b, int'($urandom), 2, 1);
    cfg_start = 1'b1;
    @(posedge clk); #1;
    cfg_start = 1'b0;
    for (int k = 0; k < 60 && !seen; k++) begin
      @(negedge clk);
      if (xbox.mem_req && xbox.mem_gnt && !xbox.mem_we && xbox.mem_addr == a[ADDR_W-1:0] && n_r2 == 1)
        seen = 1;
    end
    if (!seen) fail("abort_wait_r1_timeout");
    @(posedge clk); #1;
    cfg_abort = 1'b1;
    @(posedge clk); #1;
    cfg_abort = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    repeat (10) @(negedge clk);
    chk("abort_drain", exp_txn.size() + exp_end.size(), 0);
  endtask

  task automatic reset_midpass();
    push_model(16'h0040, 16'h0080, 16'h00C0, 3, 2, 1'b0);
    @(posedge clk); #1;
    drive_cfg(16'h0040, 16'h0080, 16'h00C0, 3, 2);
    cfg_start = 1'b1;
    @(posedge clk); #1;
    cfg_start = 1'b0;
    repeat (8) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk("async_reset_outputs", {busy, done, err, xbox.mem_req, xbox.mem_we, xbox.mem_addr,
                                    xbox.ld_r1, xbox.ld_r2, xbox.cmp_start}, 0);
    exp_txn.delete();
    exp_end.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_outputs", {busy, done, err, xbox.mem_req, xbox.mem_we, xbox.mem_addr,
                          xbox.ld_r1, xbox.ld_r2, xbox.cmp_start}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Nominal pass, immediate grant, rvalid +1, cmp_done +2.
    gnt_mode = 0; rv_mode = 0; cmp_mode = 1;
    run_pass(32'h100, 32'h200, 32'h300, 3, 2, 1'b0, 1'b0);
    // Back-pressure: grant after 5 stalled cycles on every request.
    gnt_mode = 1;
    run_pass(32'h100, 32'h200, 32'h300, 3, 2, 1'b0, 1'b0);
    gnt_mode = 0;
    // Zero dimensions, then a valid pass clears err.
    zero_dim(0, 2);
    zero_dim(3, 0);
    run_pass(32'h010, 32'h020, 32'h030, 1, 1, 1'b0, 1'b0);
    // Result pointer wrap.
    run_pass(32'h3FFE, 32'h3FFF, 32'h3FFF, 2, 1, 1'b0, 1'b0);
    // Watchdog.
    cmp_mode = 0;
    run_pass(32'h111, 32'h222, 32'h333, 1, 1, 1'b1, 1'b0);
    cmp_mode = 1;
    // Abort in WAIT_R1 with a late rvalid.
    abort_test();
    rv_mode = 0;
    // Start pulse and cfg changes mid-pass are ignored.
    run_pass(32'h100, 32'h200, 32'h300, 3, 2, 1'b0, 1'b1);
    // Randomized passes.
    gnt_mode = 2; rv_mode = 2; cmp_mode = 2;
    for (int p = 0; p < 8; p++) begin
      int nin = int'($urandom_range(1, 4));
      int nw  = int'($urandom_range(1, 3));
      run_pass(int'($urandom_range(0, 16383)), int'($urandom_range(0, 16383)),
               int'($urandom_range(16370, 16383)), nin, nw, 1'b0, (nin * nw >= 2));
    end
    // Asynchronous reset mid-pass, then a clean pass.
    gnt_mode = 0; rv_mode = 0; cmp_mode = 1;
    reset_midpass();
    run_pass(32'h005, 32'h006, 32'h007, 2, 2, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
